cla_chunk_sequencer: RTL
========================

Name: cla_chunk_sequencer

Overview:
Multi-cycle controller that computes wide additions with one NBIT-bit decomposed CLA slice (linear + non-linear parts, instantiated outside this block). Captures W = NBIT*NCHUNK-bit operands through a valid/ready handshake, feeds the slice one chunk per cycle LSB-first, chains the carry, and assembles the sum. Sits between the operand source and the CLA slice; owns all sequencing and handshake logic.

Parameters:
NBIT, 7, width of the external CLA slice
NCHUNK, 4, chunks per operation; W = NBIT*NCHUNK (28 by default); NCHUNK >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand request
in_ready  out  1  high only in IDLE
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  carry in
add_a  out  NBIT  chunk of A to slice
add_b  out  NBIT  chunk of B to slice
add_c  out  1  carry to slice
add_s  in  NBIT  slice sum, combinational same cycle
add_co  in  1  slice carry out, combinational same cycle
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_sum  out  W  result sum
out_cout  out  1  final carry out
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset decided: single clock clk; rst synchronous, active-high.
- States: IDLE, RUN, DONE. Index counter idx is ceil(log2(NCHUNK)) bits wide.
- Reset (any state, including mid-RUN): next state IDLE; idx=0; out_valid=0; out_sum=0; out_cout=0; busy=0; add_a/add_b/add_c=0; in_ready=1 from the first post-reset cycle. An operation in flight is dropped silently.
- IDLE: in_ready=1. When in_valid=1, latch in_a, in_b and in_cin, set idx=0, go to RUN. Operands are sampled only on that edge.
- RUN: in_ready=0. Drive add_a = a_reg[idx*NBIT +: NBIT] and add_b likewise from b_reg. Drive add_c = cin_reg when idx=0, otherwise carry_reg. On each edge, store add_s into sum_reg chunk idx and add_co into carry_reg.
- RUN exit: when idx=NCHUNK-1, go to DONE; otherwise increment idx.
- DONE: out_valid=1; out_sum=sum_reg; out_cout=carry_reg. Both are held stable until out_ready=1, then go to IDLE. in_valid is ignored in DONE.
- Operand drives: add_a/add_b/add_c = 0 outside RUN.
- Timing: request accepted at edge t → out_valid high from cycle t+NCHUNK+1. Minimum spacing between accepted requests is NCHUNK+2 cycles (one IDLE bubble; no overlap).
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(W+1).

Optional Feature:
Macro CLA_SEQ_SUB_EN.
- Defined: adds port in_sub (in, 1), latched with the operands. When in_sub=1, add_b = ~chunk of b_reg and chunk 0 carry is forced to 1 (in_cin ignored). Result is in_a - in_b mod 2^W; out_cout=1 means no borrow.
- Undefined: no in_sub port; add only.

Decomposition:
- Package cla_seq_pkg holds: state enum (IDLE/RUN/DONE), default NBIT and NCHUNK constants, and a function computing W and the idx width.
- One natural sub-module: cla_seq_chunk_buf. It holds the operand registers, the chunk-select mux for add_a/add_b, and sum-chunk write-back. The FSM, idx counter and handshake stay in the top.

Test Plan:
(All with NBIT=7, NCHUNK=4.)
1. Reset: assert rst for 2 cycles mid-stream → every output 0 except in_ready=1 in the cycle after rst deasserts.
2. Full carry ripple: in_a=0x0FFFFFFF, in_b=0x0000001, cin=0 → add_c sequence 0,1,1,1 across RUN; out_sum=0x0000000, out_cout=1; out_valid exactly 5 cycles after the accept edge.
3. Mixed values: in_a=0x1234567, in_b=0x0ABCDEF, cin=1 → out_sum=0x1CF1357, out_cout=0.
4. Backpressure: out_ready=0 for 10 cycles with in_valid=1 and changing operands → out_valid and out_sum stable, in_ready=0. After out_ready=1, one IDLE cycle, then the new request is accepted.
5. Reset during RUN at idx=2 → IDLE next cycle, out_valid never asserted for the dropped op; the following op a=3, b=4 → out_sum=7.
6. CLA_SEQ_SUB_EN: a=5, b=7, in_sub=1 → out_sum=0xFFFFFFE, out_cout=0. Then a=7, b=5 → out_sum=2, out_cout=1.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the chunked CLA sequencer.
package cla_seq_pkg;
  localparam int NBIT_DEF   = 7;
  localparam int NCHUNK_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cla_w(input int nbit, input int nchunk);
    return nbit * nchunk;
  endfunction

  function automatic int idx_w(input int nchunk);
    return (nchunk < 2) ? 1 : $clog2(nchunk);
  endfunction
endpackage

// File: rtl/cla_seq_chunk_buf.sv
// Operand/sum chunk storage: latches operands, muxes the active chunk to the
// slice and writes the slice sum back. CLA_SEQ_SUB_EN adds subtract support.
module cla_seq_chunk_buf
  import cla_seq_pkg::*;
#(
  parameter int NBIT   = NBIT_DEF,
  parameter int NCHUNK = NCHUNK_DEF,
  parameter int IW     = idx_w(NCHUNK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [IW-1:0]          idx,
  input  logic [NBIT*NCHUNK-1:0] in_a,
  input  logic [NBIT*NCHUNK-1:0] in_b,
  input  logic                   in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  input  logic [NBIT-1:0]        add_s,
  output logic [NBIT-1:0]        add_a,
  output logic [NBIT-1:0]        add_b,
  output logic                   cin_q,
  output logic [NBIT*NCHUNK-1:0] sum
);
  logic [NCHUNK-1:0][NBIT-1:0] a_reg, b_reg, s_reg;
  logic                        cin_reg;

  // Subtraction is folded in at load time: b is stored inverted and the
  // initial carry forced, so the run datapath is identical for both ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
    end else if (load) begin
      a_reg   <= in_a;
`ifdef CLA_SEQ_SUB_EN
      b_reg   <= in_sub ? ~in_b : in_b;
      cin_reg <= in_sub ? 1'b1 : in_cin;
`else
      b_reg   <= in_b;
      cin_reg <= in_cin;
`endif
    end
  end

  for (genvar k = 0; k < NCHUNK; k++) begin : g_wb
    always_ff @(posedge clk) begin
      if (rst)                          s_reg[k] <= '0;
      else if (run && idx == IW'(k))    s_reg[k] <= add_s;
    end
  end

  assign add_a = run ? a_reg[idx] : '0;
  assign add_b = run ? b_reg[idx] : '0;
  assign cin_q = cin_reg;
  assign sum   = s_reg;
endmodule

// File: rtl/cla_chunk_sequencer.sv
// Sequences a W-bit add through one external NBIT-bit CLA slice, LSB chunk
// first, with valid/ready on both sides. Optional macro: CLA_SEQ_SUB_EN.
module cla_chunk_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NBIT   = NBIT_DEF,
  parameter int NCHUNK = NCHUNK_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBIT*NCHUNK-1:0] in_a,
  input  logic [NBIT*NCHUNK-1:0] in_b,
  input  logic                   in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  output logic [NBIT-1:0]        add_a,
  output logic [NBIT-1:0]        add_b,
  output logic                   add_c,
  input  logic [NBIT-1:0]        add_s,
  input  logic                   add_co,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBIT*NCHUNK-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);
  localparam int W  = cla_w(NBIT, NCHUNK);
  localparam int IW = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry_reg;
  logic          cin_q;
  logic          load, run;
  logic [W-1:0]  sum;

  assign load = (state == IDLE) && in_valid;
  assign run  = (state == RUN);

  cla_seq_chunk_buf #(.NBIT(NBIT), .NCHUNK(NCHUNK), .IW(IW)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .run    (run),
    .idx    (idx),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_cin (in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub (in_sub),
`endif
    .add_s  (add_s),
    .add_a  (add_a),
    .add_b  (add_b),
    .cin_q  (cin_q),
    .sum    (sum)
  );

  assign add_c    = run ? ((idx == '0) ? cin_q : carry_reg) : 1'b0;
  assign out_sum  = sum;
  assign out_cout = carry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= RUN;
          idx      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          carry_reg <= add_co;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
